// File: rtl/spi_loader_pkg.sv
// rtl/spi_loader_pkg.sv - shared constants and FSM state type for the SPI loader
package spi_loader_pkg;

    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] CMD_ADDR = 8'h01;
    localparam logic [BYTE_W-1:0] CMD_DATA = 8'h02;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        WRITE = 2'd3
    } state_e;

endpackage

// File: rtl/spi_loader_if.sv
// rtl/spi_loader_if.sv - SPI pad and memory write-port bundle for the SPI loader
interface spi_loader_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              overflow;

    // Loader side: consumes the SPI pads, drives the memory write port.
    modport slave (
        input  sclk,
        input  cs_n,
        input  mosi,
        output miso,
        output wr_valid,
        input  wr_ready,
        output wr_addr,
        output wr_data,
        output overflow
    );

    // External side: SPI master plus the memory that accepts writes.
    modport master (
        output sclk,
        output cs_n,
        output mosi,
        input  miso,
        input  wr_valid,
        output wr_ready,
        input  wr_addr,
        input  wr_data,
        input  overflow
    );

endinterface

// File: rtl/spi_slave_byte.sv
// rtl/spi_slave_byte.sv - SPI mode-0 byte receiver with one-byte-delayed loopback transmitter
module spi_slave_byte
    import spi_loader_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk_i,
    input  logic              cs_n_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              byte_valid_o,
    output logic [BYTE_W-1:0] rx_byte_o,
    input  logic [BYTE_W-1:0] tx_byte_i
);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;

    logic sclk_s;
    logic cs_s;
    logic mosi_s;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;

    logic [BYTE_W-1:0] rx_shift_q, rx_shift_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic              byte_valid_q, byte_valid_d;
    logic [BYTE_W-1:0] rx_byte_q, rx_byte_d;
    logic [BYTE_W-1:0] tx_shift_q, tx_shift_d;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;

    // Bring the pad signals into the clk domain and keep one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    // Next-state for the shift registers: sample on sclk rise, drive on sclk fall.
    always_comb begin
        rx_shift_d   = rx_shift_q;
        bit_cnt_d    = bit_cnt_q;
        byte_valid_d = 1'b0;
        rx_byte_d    = rx_byte_q;
        tx_shift_d   = tx_shift_q;

        if (cs_rise) begin
            bit_cnt_d  = 3'd0;
            rx_shift_d = '0;
        end else if (!cs_s && sclk_rise) begin
            rx_shift_d = {rx_shift_q[BYTE_W-2:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                byte_valid_d = 1'b1;
                rx_byte_d    = rx_shift_d;
                tx_shift_d   = rx_shift_d;
            end
        end

        // The fall that follows the 8th rise must not shift, or the freshly loaded
        // MSB would be lost before the master samples it on the next rise.
        if (cs_fall) begin
            tx_shift_d = tx_byte_i;
        end else if (!cs_s && sclk_fall && (bit_cnt_q != 3'd0)) begin
            tx_shift_d = {tx_shift_q[BYTE_W-2:0], 1'b0};
        end
    end

    // Shift-register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shift_q   <= '0;
            bit_cnt_q    <= 3'd0;
            byte_valid_q <= 1'b0;
            rx_byte_q    <= '0;
            tx_shift_q   <= '0;
        end else begin
            rx_shift_q   <= rx_shift_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_valid_q <= byte_valid_d;
            rx_byte_q    <= rx_byte_d;
            tx_shift_q   <= tx_shift_d;
        end
    end

    assign miso_o       = tx_shift_q[BYTE_W-1];
    assign byte_valid_o = byte_valid_q;
    assign rx_byte_o    = rx_byte_q;

endmodule

// File: rtl/spi_loader.sv
// rtl/spi_loader.sv - SPI command decoder issuing 32-bit memory writes
module spi_loader
    import spi_loader_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    spi_loader_if.slave  bus
);

    logic              byte_valid;
    logic [BYTE_W-1:0] rx_byte;
    logic              wr_accept;
    logic [ADDR_W-1:0] addr_base;
    logic              last_byte;

    state_e            state_q;
    logic [1:0]        byte_idx_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              wr_valid_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              overflow_q;

    spi_slave_byte #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_byte (
        .clk          (clk),
        .rst_n        (rst_n),
        .sclk_i       (bus.sclk),
        .cs_n_i       (bus.cs_n),
        .mosi_i       (bus.mosi),
        .miso_o       (bus.miso),
        .byte_valid_o (byte_valid),
        .rx_byte_o    (rx_byte),
        .tx_byte_i    (rx_byte)
    );

    assign wr_accept = wr_valid_q & bus.wr_ready;
    assign last_byte = (byte_idx_q == 2'(BYTES_PER_WORD - 1));

    // An accepted write advances the address even if an address byte lands in the same cycle.
    assign addr_base = wr_accept ? (addr_q + ADDR_W'(BYTES_PER_WORD)) : addr_q;

    // Command decoder and write handshake; the write request is tracked by wr_valid_q
    // so that new commands can be decoded while a write is still pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            byte_idx_q <= 2'd0;
            addr_q     <= '0;
            data_q     <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_valid_q <= 1'b0;
                addr_q     <= addr_base;
                if (state_q == WRITE) begin
                    state_q <= IDLE;
                end
            end

            if (byte_valid) begin
                case (state_q)
                    IDLE, WRITE: begin
                        if (rx_byte == CMD_ADDR) begin
                            state_q    <= ADDR;
                            byte_idx_q <= 2'd0;
                        end else if (rx_byte == CMD_DATA) begin
                            state_q    <= DATA;
                            byte_idx_q <= 2'd0;
                        end
                    end
                    ADDR: begin
                        addr_q     <= {addr_base[ADDR_W-BYTE_W-1:0], rx_byte};
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (last_byte) begin
                            state_q <= IDLE;
                        end
                    end
                    DATA: begin
                        data_q     <= {data_q[DATA_W-BYTE_W-1:0], rx_byte};
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (last_byte) begin
                            if (wr_valid_q) begin
                                overflow_q <= 1'b1;
                                state_q    <= IDLE;
                            end else begin
                                wr_valid_q <= 1'b1;
                                wr_addr_q  <= addr_q;
                                wr_data_q  <= {data_q[DATA_W-BYTE_W-1:0], rx_byte};
                                state_q    <= WRITE;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.wr_valid = wr_valid_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_spi_loader.sv
// tb/tb_spi_loader.sv - self-checking bench for spi_loader
module tb_spi_loader;

    localparam int HALF = 5;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    spi_loader_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    spi_loader #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int          m_cmd;
    int          m_cnt;
    logic [31:0] m_acc;
    logic [31:0] m_addr;
    logic [7:0]  m_prev;
    logic        m_pending;
    logic        m_ovf;
    logic [63:0] exp_q[$];

    // observed writes
    logic [63:0] got_q[$];
    int          valid_cycles = 0;
    logic        prev_v = 1'b0;
    logic        prev_acc = 1'b0;
    logic [63:0] prev_aw = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // write-port monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (rst_n && bus.wr_valid) begin
            valid_cycles++;
            if (prev_v && !prev_acc) begin
                n_cmp++;
                assert ({bus.wr_addr, bus.wr_data} === prev_aw) else begin
                    n_bad++;
                    $error("FAIL wr_stable: observed %0h expected %0h", {bus.wr_addr, bus.wr_data}, prev_aw);
                end
            end
            if (bus.wr_ready) got_q.push_back({bus.wr_addr, bus.wr_data});
        end
        prev_v   = rst_n && bus.wr_valid;
        prev_acc = rst_n && bus.wr_valid && bus.wr_ready;
        prev_aw  = {bus.wr_addr, bus.wr_data};
    end

    task automatic ticks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_cmd = 0; m_cnt = 0; m_acc = '0; m_addr = '0;
        m_prev = '0; m_pending = 1'b0; m_ovf = 1'b0;
    endtask

    // command-level behaviour: 01 + 4 bytes sets address, 02 + 4 bytes writes a word
    task automatic model_byte(input logic [7:0] b);
        if (m_cmd == 0) begin
            if (b == 8'h01) begin m_cmd = 1; m_cnt = 0; m_acc = '0; end
            else if (b == 8'h02) begin m_cmd = 2; m_cnt = 0; m_acc = '0; end
        end else begin
            m_acc = (m_acc << 8) | {24'd0, b};
            m_cnt++;
            if (m_cnt == 4) begin
                if (m_cmd == 1) m_addr = m_acc;
                else if (m_pending) m_ovf = 1'b1;
                else begin
                    exp_q.push_back({m_addr, m_acc});
                    if (bus.wr_ready) m_addr = m_addr + 32'd4;
                    else m_pending = 1'b1;
                end
                m_cmd = 0;
            end
        end
    endtask

    task automatic set_ready(input logic r);
        bus.wr_ready = r;
        if (r && m_pending) begin
            m_pending = 1'b0;
            m_addr = m_addr + 32'd4;
        end
    endtask

    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        logic [7:0] sh;
        sh = tx;
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = sh[7];
            sh = sh << 1;
            ticks(HALF);
            rx = {rx[6:0], bus.miso};
            bus.sclk = 1'b1;
            ticks(HALF);
            bus.sclk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [7:0] got;
        spi_xfer(b, 8, got);
        chk($sformatf("loopback_%02h", b), {56'd0, got}, {56'd0, m_prev});
        m_prev = b;
        model_byte(b);
    endtask

    task automatic send_cmd(input logic [7:0] cmd, input logic [31:0] w);
        logic [31:0] sh;
        sh = w;
        send_byte(cmd);
        for (int i = 0; i < 4; i++) begin
            send_byte(sh[31:24]);
            sh = sh << 8;
        end
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
        chk({tag, "_overflow"}, {63'd0, bus.overflow}, {63'd0, m_ovf});
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_miso"},     {63'd0, bus.miso},     64'd0);
        chk({tag, "_wr_valid"}, {63'd0, bus.wr_valid}, 64'd0);
        chk({tag, "_wr_addr"},  {32'd0, bus.wr_addr},  64'd0);
        chk({tag, "_wr_data"},  {32'd0, bus.wr_data},  64'd0);
        chk({tag, "_overflow"}, {63'd0, bus.overflow}, 64'd0);
    endtask

    initial begin
        logic [31:0] a;
        int          nj;
        logic [7:0]  junk;

        rst_n = 1'b0;
        bus.sclk = 1'b0;
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        bus.wr_ready = 1'b1;
        model_reset();
        ticks(3);
        check_zero("reset");
        rst_n = 1'b1;
        ticks(2);
        bus.cs_n = 1'b0;
        ticks(2 * HALF);

        // address then one word, memory always ready
        send_cmd(8'h01, 32'h1000_0000);
        send_cmd(8'h02, 32'hDEAD_BEEF);
        ticks(20);
        chk("t1_valid_cycles", 64'(valid_cycles), 64'd1);
        chk("t1_write", got_q.size() > 0 ? got_q[0] : 64'hx, 64'h1000_0000_DEAD_BEEF);
        check_writes("t1");

        // auto-increment
        send_cmd(8'h02, 32'h0102_0304);
        ticks(20);
        chk("t2_write", got_q.size() > 0 ? got_q[0] : 64'hx, 64'h1000_0004_0102_0304);
        check_writes("t2");

        // back-pressure: second word dropped
        set_ready(1'b0);
        send_cmd(8'h02, $urandom());
        send_cmd(8'h02, $urandom());
        ticks(20);
        chk("t3_wr_valid", {63'd0, bus.wr_valid}, 64'd1);
        chk("t3_held", {bus.wr_addr, bus.wr_data}, exp_q.size() > 0 ? exp_q[0] : 64'hx);
        chk("t3_no_write", 64'(got_q.size()), 64'd0);
        chk("t3_overflow", {63'd0, bus.overflow}, 64'd1);
        set_ready(1'b1);
        ticks(5);
        chk("t3_valid_low", {63'd0, bus.wr_valid}, 64'd0);
        check_writes("t3");

        // partial byte discarded by a cs_n rise
        begin
            logic [7:0] dummy;
            spi_xfer(8'h01, 5, dummy);
        end
        ticks(HALF);
        bus.cs_n = 1'b1;
        ticks(2 * HALF);
        bus.cs_n = 1'b0;
        ticks(2 * HALF);
        send_cmd(8'h01, 32'h2000_0000);
        send_cmd(8'h02, $urandom());
        ticks(20);
        chk("t4_addr", got_q.size() > 0 ? {got_q[0][63:32], 32'd0} : 64'hx, 64'h2000_0000_0000_0000);
        check_writes("t4");

        // reset in the middle of a data command
        send_byte(8'h02);
        send_byte(8'hAA);
        send_byte(8'hBB);
        ticks(HALF);
        rst_n = 1'b0;
        ticks(2);
        check_zero("midreset");
        model_reset();
        rst_n = 1'b1;
        ticks(2 * HALF);

        // loopback of non-command bytes, then a word to address 0
        send_byte(8'h55);
        send_byte(8'hA3);
        ticks(20);
        chk("t5_no_write", 64'(got_q.size()), 64'd0);
        send_cmd(8'h02, 32'hCAFE_F00D);
        ticks(20);
        chk("t6_write", got_q.size() > 0 ? got_q[0] : 64'hx, 64'h0000_0000_CAFE_F00D);
        check_writes("t6");

        // randomized command streams, including address wrap at the top of the space
        for (int r = 0; r < 3; r++) begin
            a = (r == 0) ? 32'hFFFF_FFFC : $urandom();
            send_cmd(8'h01, a);
            for (int w = 0; w < 3; w++) begin
                nj = $urandom_range(0, 2);
                for (int j = 0; j < nj; j++) begin
                    junk = 8'($urandom_range(3, 255));
                    send_byte(junk);
                end
                send_cmd(8'h02, $urandom());
            end
        end
        ticks(20);
        check_writes("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_loader.md
# spi_loader

SPI mode-0 responder that receives the flash-programming byte stream from an external SPI master. It decodes the address and data commands and issues 32-bit word writes to the on-chip instruction/data memories while the core is held in reset. It sits inside the top level between the SCLK/CS/MOSI/MISO pads and the memory write port, and is clocked by the system clock.

## Interface
Parameters:
- ADDR_W, 32, write-address width
- DATA_W, 32, write-data width
- SYNC_STAGES, 2, synchronizer depth for sclk/cs_n/mosi

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset (one clock domain; the polarity and synchronicity are fixed)
- sclk  in  1  SPI clock from master, asynchronous to clk
- cs_n  in  1  SPI chip select, active low
- mosi  in  1  master-out data, MSB first
- miso  out  1  slave-out data, MSB first
- wr_valid  out  1  write request
- wr_ready  in  1  memory accepts the write
- wr_addr  out  ADDR_W  byte address of the write
- wr_data  out  DATA_W  write data
- overflow  out  1  sticky: a data word was dropped because a write was still pending

## Operation
- sclk, cs_n and mosi each pass through SYNC_STAGES flops. Edge detection runs on the synchronized sclk.
- Receive path:
  - On each synchronized sclk rising edge with cs_n low, shift mosi into rx_shift, MSB first. bit_cnt (3 bit) increments.
  - After the 8th bit, byte_valid pulses for 1 clk and bit_cnt wraps to 0.
  - A cs_n rise (synchronized) clears bit_cnt and discards any partial byte. It does not change command state; the master may toggle cs_n between bytes.
- Transmit path:
  - tx_shift is loaded with the last complete received byte (0x00 after reset) when cs_n falls and on every byte_valid.
  - miso = tx_shift[7]. It shifts left on each synchronized sclk falling edge with cs_n low.
  - The result is a one-byte-delayed loopback.
- Command FSM (states IDLE, ADDR, DATA, WRITE):
  - IDLE:
    - byte 0x01 → ADDR, byte index cleared.
    - byte 0x02 → DATA, byte index cleared.
    - any other byte is ignored and the FSM stays in IDLE.
  - ADDR: 4 bytes, MSB first, shifted into addr_reg. After the 4th byte, go to IDLE.
  - DATA: 4 bytes, MSB first, shifted into data_reg. After the 4th byte:
    - if wr_valid is low: go to WRITE.
    - if wr_valid is already high: set overflow, drop the word, go to IDLE.
  - WRITE: wr_valid=1, wr_addr=addr_reg, wr_data=data_reg. Hold until wr_ready is sampled high. Then:
    - deassert wr_valid,
    - addr_reg += 4 (wraps modulo 2^ADDR_W),
    - go to IDLE.
  - Bytes received while in WRITE are treated as IDLE decoding. A 0x01 arriving in WRITE therefore starts ADDR, but addr_reg is updated only after the pending write is accepted.
- wr_addr and wr_data stay stable while wr_valid is high.
- Reset mid-operation: every register returns to its reset value immediately and any partial command is lost.
- Reset values:
  - miso=0, wr_valid=0, wr_addr=0, wr_data=0, overflow=0
  - FSM=IDLE, addr_reg=0, data_reg=0, tx_shift=0, bit_cnt=0

## Timing
- Requires f_sclk ≤ f_clk/8. Each sclk phase must be ≥ 4 clk.
- mosi must be stable across the sampled sclk rise plus SYNC_STAGES clk.
- byte_valid occurs SYNC_STAGES+1 clk after the pad-level 8th sclk rise.
- wr_valid rises 1 clk after the byte_valid of the 4th data byte.
- A write completes on the first clk edge where wr_valid && wr_ready. With wr_ready tied high, wr_valid is high for exactly 1 clk.
- miso changes SYNC_STAGES+1 clk after a pad-level sclk fall, which is within a half sclk period at the minimum ratio.
- A full word needs 10 bytes (1+4+1+4), or 5 bytes with auto-increment.

## Structure
- Package spi_loader_pkg holds:
  - CMD_ADDR=8'h01, CMD_DATA=8'h02
  - the FSM state enum (IDLE, ADDR, DATA, WRITE)
  - BYTES_PER_WORD=4
- One sub-module, spi_slave_byte: synchronizers, edge detect, rx/tx shift registers, bit_cnt, byte_valid/rx_byte out, tx_byte in.
- spi_loader contains the command FSM, addr/data registers and the write handshake.

## Test plan
- Stream 01 10 00 00 00 02 DE AD BE EF with wr_ready=1 → one write, addr 0x1000_0000, data 0xDEADBEEF. wr_valid is high for 1 clk.
- Continue with 02 01 02 03 04 and no new address → write to 0x1000_0004, data 0x01020304.
- Hold wr_ready=0, send two complete data commands → first word is held stable on wr_*, second word is dropped, overflow=1. Release wr_ready → exactly one write completes.
- Toggle cs_n high after 5 bits of a byte, then resend the full address command 01 20 00 00 00 → partial byte discarded, addr_reg=0x2000_0000.
- Send bytes 0x55 then 0xA3 → miso returns 0x00 then 0x55 (one-byte loopback). 0x55 and 0xA3 are not commands, so the FSM stays in IDLE and no write occurs.
- Assert rst_n low after the 2nd data byte, then release and send 02 + 4 bytes → write goes to addr 0x0000_0000, and all outputs read 0 during reset.
